// File: rtl/teclado_matriz_scanner.sv
// rtl/teclado_matriz_scanner.sv - key matrix row scanner with per-key debounce and press pulses
module teclado_matriz_scanner #(
    parameter int ROWS     = 2,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [COLS-1:0]      i_colunas_teclado,
    output logic [ROWS-1:0]      o_linhas_teclado,
    output logic [ROWS*COLS-1:0] o_botoes_estado,
    output logic [ROWS*COLS-1:0] o_botoes_pulso,
    output logic                 o_quadro_fim
);

    localparam int KEYS = ROWS * COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW   = $clog2(DEBOUNCE + 1);

    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_div;
    logic            r_active;
    logic [ROWS-1:0] r_linhas;
    logic [KEYS-1:0] r_estado;
    logic [KEYS-1:0] r_pulso;
    logic            r_quadro;
    logic [CW-1:0]   r_deb [KEYS];

    logic            w_sample;
    logic            w_last_row;
    logic [RW-1:0]   w_row_next;
    logic [KEYS-1:0] w_estado_next;
    logic [KEYS-1:0] w_pulso_next;
    logic [CW-1:0]   w_deb_next [KEYS];

    assign w_sample   = r_active && (r_div == DW'(SCAN_DIV - 1));
    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_row_next = w_last_row ? '0 : r_row + 1'b1;

    // Only the keys of the row being sampled move; everything else holds.
    always_comb begin
        w_estado_next = r_estado;
        w_pulso_next  = '0;
        for (int k = 0; k < KEYS; k++) begin
            w_deb_next[k] = r_deb[k];
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (w_sample && (r_row == RW'(r))) begin
                    if ((~r_sync2[c]) == r_estado[r*COLS+c]) begin
                        w_deb_next[r*COLS+c] = '0;
                    end else if (r_deb[r*COLS+c] == CW'(DEBOUNCE - 1)) begin
                        w_estado_next[r*COLS+c] = ~r_sync2[c];
                        w_pulso_next[r*COLS+c]  = ~r_sync2[c];
                        w_deb_next[r*COLS+c]    = '0;
                    end else begin
                        w_deb_next[r*COLS+c] = r_deb[r*COLS+c] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_row    <= '0;
            r_div    <= '0;
            r_active <= 1'b0;
            r_linhas <= '1;
            r_estado <= '0;
            r_pulso  <= '0;
            r_quadro <= 1'b0;
            r_deb    <= '{default: '0};
        end else begin
            r_sync1  <= i_colunas_teclado;
            r_sync2  <= r_sync1;
            r_estado <= w_estado_next;
            r_pulso  <= w_pulso_next;
            r_deb    <= w_deb_next;
            r_quadro <= w_sample && w_last_row;
            if (!r_active) begin
                // First edge out of reset starts driving row 0.
                r_active <= 1'b1;
                r_linhas <= ~ROWS'(1);
            end else if (w_sample) begin
                r_div    <= '0;
                r_row    <= w_row_next;
                r_linhas <= ~(ROWS'(1) << w_row_next);
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_linhas_teclado = r_linhas;
    assign o_botoes_estado  = r_estado;
    assign o_botoes_pulso   = r_pulso;
    assign o_quadro_fim     = r_quadro;

endmodule
